// File: rtl/gate_truth_table_analyzer.sv
// ============================================================================
// Module   : gate_truth_table_analyzer
// Function : Drives all four vectors into a 2-input gate and reports its
//            truth table, gate identity and universality.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_truth_table_analyzer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       probe_a,
   output logic       probe_b,
   input  logic       probe_y,
   output logic       busy,
   output logic       done,
   output logic [3:0] truth_table,
   output logic [2:0] gate_code,
   output logic       is_universal
);

   generate
      if (SETTLE_CYCLES < 1) begin : g_bad_settle
         $error("SETTLE_CYCLES must be at least 1");
      end
   endgenerate

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_DRIVE    = 2'd1;
   localparam logic [1:0] S_CLASSIFY = 2'd2;
   localparam logic [1:0] S_DONE     = 2'd3;

   localparam logic [2:0] C_UNKNOWN = 3'd0;
   localparam logic [2:0] C_AND     = 3'd1;
   localparam logic [2:0] C_OR      = 3'd2;
   localparam logic [2:0] C_NAND    = 3'd3;
   localparam logic [2:0] C_NOR     = 3'd4;
   localparam logic [2:0] C_XOR     = 3'd5;
   localparam logic [2:0] C_XNOR    = 3'd6;
   localparam logic [2:0] C_CONST   = 3'd7;

   logic [1:0]       state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       shadow_q, shadow_d;
   logic [1:0]       probe_q, probe_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [3:0]       table_q, table_d;
   logic [2:0]       code_q, code_d;
   logic             univ_q, univ_d;
   logic [2:0]       decoded;

   // Bit i of the shadow table holds y sampled with {a,b} = i
   always_comb begin
      decoded = C_UNKNOWN;
      case (shadow_q)
         4'b1000:          decoded = C_AND;
         4'b1110:          decoded = C_OR;
         4'b0111:          decoded = C_NAND;
         4'b0001:          decoded = C_NOR;
         4'b0110:          decoded = C_XOR;
         4'b1001:          decoded = C_XNOR;
         4'b0000, 4'b1111: decoded = C_CONST;
         default:          decoded = C_UNKNOWN;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      probe_d  = probe_q;
      busy_d   = busy_q;
      done_d   = done_q;
      table_d  = table_q;
      code_d   = code_q;
      univ_d   = univ_q;
      case (state_q)
         S_IDLE: begin
            probe_d = 2'b00;
            if (start) begin
               state_d = S_DRIVE;
               idx_d   = 2'd0;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         S_DRIVE: begin
            if (cnt_q == C_CNT_LAST) begin
               // Window closes: y has had the full settle time
               shadow_d[idx_q] = probe_y;
               cnt_d           = '0;
               if (idx_q == 2'd3) begin
                  state_d = S_CLASSIFY;
                  probe_d = 2'b00;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  probe_d = idx_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CLASSIFY: begin
            state_d = S_DONE;
            table_d = shadow_q;
            code_d  = decoded;
            univ_d  = (decoded == C_NAND) || (decoded == C_NOR);
            done_d  = 1'b1;
         end
         S_DONE: begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            probe_d = 2'b00;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= 2'd0;
         cnt_q    <= '0;
         shadow_q <= 4'd0;
         probe_q  <= 2'b00;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         table_q  <= 4'd0;
         code_q   <= 3'd0;
         univ_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         probe_q  <= probe_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         table_q  <= table_d;
         code_q   <= code_d;
         univ_q   <= univ_d;
      end
   end

   assign probe_a      = probe_q[1];
   assign probe_b      = probe_q[0];
   assign busy         = busy_q;
   assign done         = done_q;
   assign truth_table  = table_q;
   assign gate_code    = code_q;
   assign is_universal = univ_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_truth_table_analyzer.sv
// ============================================================================
// Module   : tb_gate_truth_table_analyzer
// Function : Randomized self-checking bench with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_truth_table_analyzer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       st1, st2, pa1, pb1, pa2, pb2, y1, y2;
   logic       bz1, bz2, dn1, dn2, un1, un2;
   logic [3:0] tt1, tt2;
   logic [2:0] gc1, gc2;
   logic [3:0] fn1, fn2;
   logic       gl1, gl2;

   assign y1 = fn1[{pa1, pb1}] ^ gl1;
   assign y2 = fn2[{pa2, pb2}] ^ gl2;

   gate_truth_table_analyzer #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .start(st1), .probe_a(pa1), .probe_b(pb1),
      .probe_y(y1), .busy(bz1), .done(dn1), .truth_table(tt1),
      .gate_code(gc1), .is_universal(un1));

   gate_truth_table_analyzer #(.SETTLE_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst), .start(st2), .probe_a(pa2), .probe_b(pb2),
      .probe_y(y2), .busy(bz2), .done(dn2), .truth_table(tt2),
      .gate_code(gc2), .is_universal(un2));

   int n_checks = 0;
   int n_errors = 0;
   logic [3:0] prev_tt [2];
   logic [2:0] prev_gc [2];
   logic       prev_un [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference decode: match against the list of named gate tables
   function automatic logic [2:0] ref_code(input logic [3:0] t);
      logic [3:0] pats [6];
      pats = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001};
      if (t == 4'b0000 || t == 4'b1111) return 3'd7;
      for (int i = 0; i < 6; i++)
         if (t == pats[i]) return 3'(i + 1);
      return 3'd0;
   endfunction

   task automatic set_start(input int s, input logic v);
      if (s == 1) st1 = v; else st2 = v;
   endtask

   task automatic set_gl(input int s, input logic v);
      if (s == 1) gl1 = v; else gl2 = v;
   endtask

   task automatic get_outs(input int s, output logic [1:0] pr, output logic bz, output logic dn,
                           output logic [3:0] tt, output logic [2:0] gc, output logic un);
      if (s == 1) begin
         pr = {pa1, pb1}; bz = bz1; dn = dn1; tt = tt1; gc = gc1; un = un1;
      end else begin
         pr = {pa2, pb2}; bz = bz2; dn = dn2; tt = tt2; gc = gc2; un = un2;
      end
   endtask

   // One full scan on instance with settle s; cycle k counted from the accepting edge
   task automatic run_scan(input int s, input logic [3:0] fn, input bit keep,
                           input bit stray, input bit glitch);
      int n;
      logic [1:0] pr;
      logic bz, dn, un;
      logic [3:0] tt;
      logic [2:0] gc;
      logic [3:0] e_tt;
      logic [2:0] e_gc;
      logic e_un;
      n = 4 * s;
      if (s == 1) fn1 = fn; else fn2 = fn;
      set_start(s, 1'b1);
      @(posedge clk);
      for (int k = 1; k <= n + 3; k++) begin
         @(negedge clk);
         if (k == 1 && !keep) set_start(s, 1'b0);
         if (stray) begin
            if (k == 3 || k == n + 1) set_start(s, 1'b1);
            else if ((k == 4 || k == n + 2) && !keep) set_start(s, 1'b0);
         end
         if (glitch && k <= n && (k % s) != 0) set_gl(s, 1'($urandom % 2));
         else set_gl(s, 1'b0);
         get_outs(s, pr, bz, dn, tt, gc, un);
         check("probe", 32'(pr), (k <= n) ? 32'((k - 1) / s) : 32'd0);
         check("busy", 32'(bz), 32'(k <= n + 2));
         check("done", 32'(dn), 32'(k == n + 2));
         if (k >= n + 2) begin
            e_tt = fn;
            e_gc = ref_code(fn);
            e_un = (e_gc == 3'd3) || (e_gc == 3'd4);
         end else begin
            e_tt = prev_tt[s-1];
            e_gc = prev_gc[s-1];
            e_un = prev_un[s-1];
         end
         check("truth_table", 32'(tt), 32'(e_tt));
         check("gate_code", 32'(gc), 32'(e_gc));
         check("is_universal", 32'(un), 32'(e_un));
      end
      prev_tt[s-1] = fn;
      prev_gc[s-1] = ref_code(fn);
      prev_un[s-1] = (ref_code(fn) == 3'd3) || (ref_code(fn) == 3'd4);
   endtask

   task automatic check_all_zero(input int s, input string tag);
      logic [1:0] pr;
      logic bz, dn, un;
      logic [3:0] tt;
      logic [2:0] gc;
      get_outs(s, pr, bz, dn, tt, gc, un);
      check({tag, "_probe"}, 32'(pr), 32'd0);
      check({tag, "_busy"}, 32'(bz), 32'd0);
      check({tag, "_done"}, 32'(dn), 32'd0);
      check({tag, "_tt"}, 32'(tt), 32'd0);
      check({tag, "_gc"}, 32'(gc), 32'd0);
      check({tag, "_univ"}, 32'(un), 32'd0);
   endtask

   task automatic reset_mid_scan();
      logic [1:0] pr;
      logic bz, dn, un;
      logic [3:0] tt;
      logic [2:0] gc;
      fn2 = 4'b0110;
      st2 = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) st2 = 1'b0;
         if (k == 4) rst = 1'b1;
      end
      @(negedge clk);
      check_all_zero(2, "mid_rst");
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         get_outs(2, pr, bz, dn, tt, gc, un);
         check("post_rst_done", 32'(dn), 32'd0);
         check("post_rst_busy", 32'(bz), 32'd0);
      end
      for (int i = 0; i < 2; i++) begin
         prev_tt[i] = 4'd0; prev_gc[i] = 3'd0; prev_un[i] = 1'b0;
      end
   endtask

   initial begin
      int s;
      rst = 1'b1; st1 = 1'b0; st2 = 1'b0;
      fn1 = 4'd0; fn2 = 4'd0; gl1 = 1'b0; gl2 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         prev_tt[i] = 4'd0; prev_gc[i] = 3'd0; prev_un[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero(1, "reset1");
      check_all_zero(2, "reset2");
      rst = 1'b0;
      @(negedge clk);

      run_scan(2, 4'b0111, 1'b0, 1'b0, 1'b0);   // NAND
      run_scan(1, 4'b0001, 1'b0, 1'b0, 1'b0);   // NOR
      run_scan(2, 4'b0110, 1'b1, 1'b0, 1'b0);   // XOR, start held
      run_scan(2, 4'b1001, 1'b0, 1'b0, 1'b0);   // XNOR back-to-back
      run_scan(2, 4'b1111, 1'b0, 1'b0, 1'b0);   // constant 1
      run_scan(2, 4'b1100, 1'b0, 1'b0, 1'b0);   // y = a
      reset_mid_scan();
      run_scan(2, 4'b0111, 1'b0, 1'b0, 1'b0);
      run_scan(2, 4'b1000, 1'b0, 1'b1, 1'b0);   // stray starts ignored
      run_scan(2, 4'b1110, 1'b0, 1'b0, 1'b0);   // start in IDLE accepted

      for (int r = 0; r < 30; r++) begin
         s = 1 + int'($urandom % 2);
         run_scan(s, 4'($urandom), 1'b0, 1'($urandom % 2), 1'b1);
         repeat ($urandom % 3) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/gate_truth_table_analyzer.md
Name: gate_truth_table_analyzer

Overview:
Sequential characterizer for 2-input combinational gate blocks, including mux-built universal gates. On a start request it drives all four input vectors onto a device-under-probe. It waits a programmable settle time per vector and samples the gate output. It then reports the 4-bit truth table, a decoded gate identity, and whether the gate is universal (NAND/NOR). It sits beside the gate library as the self-check / readback end of the gate blocks.

Parameters:
SETTLE_CYCLES, 2, cycles each input vector is held before the output is sampled; must be >= 1 (0 is an elaboration error)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  scan request, accepted only in IDLE
probe_a  output  1  registered stimulus to gate input a
probe_b  output  1  registered stimulus to gate input b
probe_y  input  1  gate output (combinational function of probe_a/probe_b)
busy  output  1  high from start acceptance until done cycle inclusive
done  output  1  one-cycle pulse, results valid
truth_table  output  4  bit i = sampled y for {probe_a,probe_b} = i
gate_code  output  3  0 UNKNOWN, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 CONST
is_universal  output  1  1 when gate_code is NAND or NOR

Behaviour:
- Reset, applied synchronously and taking priority over everything: state IDLE; probe_a, probe_b, busy, done, truth_table, gate_code and is_universal all 0; settle counter and vector index cleared.
- States:
  - IDLE: probes 00. start=1 at edge E0 moves to DRIVE with vector index 0 and busy=1.
  - DRIVE: {probe_a,probe_b} = index, held exactly SETTLE_CYCLES cycles. In the last cycle of the window, probe_y is captured into a shadow bit[index] at the closing edge.
    - After index 3 is captured: go to CLASSIFY.
    - Otherwise: index+1, counter reloads.
  - CLASSIFY (1 cycle): probes return to 00. Decode the shadow table:
    - 1000 AND
    - 1110 OR
    - 0111 NAND
    - 0001 NOR
    - 0110 XOR
    - 1001 XNOR
    - 0000 or 1111 CONST
    - anything else UNKNOWN
  - DONE (1 cycle): truth_table, gate_code and is_universal update at the edge entering DONE. done=1 and busy=1 during this cycle, then the block returns to IDLE.
- Timing:
  - Vector i is driven in cycles i*S+1 .. (i+1)*S after E0 (S = SETTLE_CYCLES).
  - done is high in cycle 4*S+2 after E0.
  - busy is low again in cycle 4*S+3.
- Results are held stable from the done cycle until the next DONE. They are not cleared by a new start.
- start while busy (DRIVE/CLASSIFY/DONE) is ignored and not queued. start held high continuously re-triggers a scan from each IDLE cycle.
- Reset mid-scan aborts the scan: no done, all outputs 0 on the next cycle, and the partial shadow table is discarded.
- probe_y is sampled only at window ends; glitches earlier in a window have no effect.

Test Plan:
- NAND model (y=~(a&b)), S=2, start pulse at E0 -> probe sequence 00,00,01,01,10,10,11,11 in cycles 1-8; done=1 only in cycle 10; truth_table=0111, gate_code=3, is_universal=1.
- NOR model, S=1 -> done in cycle 6; truth_table=0001, gate_code=4, is_universal=1; busy low in cycle 7.
- XOR then XNOR models in back-to-back scans (start held high) -> 0110/code 5/univ 0, then 1001/code 6/univ 0. The first results persist until the second done.
- y tied to 1, then y=a passthrough -> 1111/code 7; then 1100/code 0 (UNKNOWN), is_universal=0.
- Reset asserted in cycle 4 of an S=2 scan -> all outputs 0 the next cycle, no done pulse. A fresh start then completes normally with correct results.
- start pulsed in cycles 3 and 9 of an S=2 scan -> ignored, exactly one done; a start in cycle 11 (IDLE) is accepted.
